// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: mode decoding, FSM state encoding and the underrun fill byte.
package spi_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic f_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic f_cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered-history edge pulses; latency STAGES cycles to the pulse.
// Reset value is a parameter so an idle line never produces a false edge on reset release.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled SCLK/CS_n/MOSI, byte strobe c_SYNC_STAGES+1 cycles after an edge.
// TX side is a single holding register; o_TX_READY is low while it is full, writes then ignored.
module spi_slave
  import spi_pkg::*;
#(
  parameter int c_SPI_MODE    = 3,
  parameter int c_SYNC_STAGES = 2
) (
  input  logic       i_CLK,
  input  logic       i_RESET_n,
  input  logic       i_SPI_CLK,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_EN,
  input  logic [7:0] i_TX_BYTE,
  input  logic       i_TX_DV,
  output logic       o_TX_READY,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_BYTE
);

  localparam logic CPOL        = f_cpol(c_SPI_MODE);
  localparam logic CPHA        = f_cpha(c_SPI_MODE);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  state_e                   state_q, state_d;
  logic                     sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [c_SYNC_STAGES-1:0] mosi_sync_q;
  logic                     mosi_s;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               rx_sr_q, rx_sr_d;
  logic [7:0]               rx_byte_q, rx_byte_d;
  logic                     rx_dv_q, rx_dv_d;
  logic [7:0]               tx_sr_q, tx_sr_d;
  logic                     miso_q, miso_d;
  logic [7:0]               hold_q, hold_d;
  logic                     hold_vld_q, hold_vld_d;
  logic                     active, cs_start, sample_edge, shift_edge, load;
  logic [7:0]               load_byte;

  spi_sync_edge #(.STAGES(c_SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk_i (i_CLK),
    .rst_ni(i_RESET_n),
    .d_i   (i_SPI_CLK),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(c_SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i (i_CLK),
    .rst_ni(i_RESET_n),
    .d_i   (i_SPI_CS_n),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // Same depth as SCLK so the sampled MOSI lines up with the detected edge.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) mosi_sync_q <= '0;
    else            mosi_sync_q <= {mosi_sync_q[c_SYNC_STAGES-2:0], i_SPI_MOSI};
  end
  assign mosi_s = mosi_sync_q[c_SYNC_STAGES-1];

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active        = (state_q == ST_ACTIVE);
    o_SPI_MISO_EN = active;
    o_SPI_MISO    = active & miso_q;
  end

  always_comb begin
    cs_start    = (state_q == ST_IDLE) && cs_fall;
    sample_edge = active && (SAMPLE_RISE ? sclk_rise : sclk_fall);
    shift_edge  = active && (SAMPLE_RISE ? sclk_fall : sclk_rise);
    load        = cs_start || (sample_edge && (bit_cnt_q == 3'd7));
    load_byte   = hold_vld_q ? hold_q : UNDERRUN_BYTE;

    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    if (cs_start) bit_cnt_d = 3'd0;

    if (sample_edge) begin
      rx_sr_d   = {rx_sr_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d = {rx_sr_q, mosi_s};
        rx_dv_d   = 1'b1;
      end
    end

    // CPHA=0 already presented bit 7 at load, so the shift edge closing a byte must not advance.
    if (shift_edge && (CPHA || (bit_cnt_q != 3'd0))) begin
      miso_d  = tx_sr_q[7];
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end

    if (load) begin
      hold_vld_d = 1'b0;
      if (CPHA) begin
        tx_sr_d = load_byte;
      end else begin
        miso_d  = load_byte[7];
        tx_sr_d = {load_byte[6:0], 1'b0};
      end
    end

    // Evaluated after the load so a same-cycle write lands in holding for the next byte.
    if (i_TX_DV && !hold_vld_q) begin
      hold_d     = i_TX_BYTE;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      bit_cnt_q  <= 3'd0;
      rx_sr_q    <= 7'd0;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      tx_sr_q    <= 8'h00;
      miso_q     <= 1'b0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign o_RX_DV    = rx_dv_q;
  assign o_RX_BYTE  = rx_byte_q;
  assign o_TX_READY = ~hold_vld_q;

endmodule
